// File: rtl/hazard_if.sv
// Decode-stage hazard signals between the pipeline datapath and hazard_unit.
// The master drives the D-stage instruction fields; the slave returns stall/forward decisions.
interface hazard_if;
    logic [4:0] d_rs_addr;
    logic [4:0] d_rt_addr;
    logic [3:0] d_rs_use;
    logic [3:0] d_rt_use;
    logic [4:0] d_dst_addr;
    logic [3:0] d_dst_save;
    logic       d_md_op;
    logic       d_md_start;
    logic       d_md_div;
    logic       stall;
    logic [1:0] fwd_rs_d;
    logic [1:0] fwd_rt_d;
    logic [1:0] fwd_rs_e;
    logic [1:0] fwd_rt_e;
    logic       md_busy;

    modport master (
        output d_rs_addr, d_rt_addr, d_rs_use, d_rt_use, d_dst_addr, d_dst_save,
               d_md_op, d_md_start, d_md_div,
        input  stall, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, md_busy
    );

    modport slave (
        input  d_rs_addr, d_rt_addr, d_rs_use, d_rt_use, d_dst_addr, d_dst_save,
               d_md_op, d_md_start, d_md_div,
        output stall, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, md_busy
    );
endinterface

// File: rtl/hazard_unit.sv
// Tuse/Tnew hazard unit: tracks E/M/W destination records, raises stall and
// forward selects for D and E operands, and times the multiply/divide unit.
module hazard_unit (
    input  logic    clk,
    input  logic    reset,
    hazard_if.slave hz
);
    localparam logic [3:0] USE_NONE      = 4'hF;
    localparam logic [3:0] MD_DIV_CYCLES = 4'd10;
    localparam logic [3:0] MD_MUL_CYCLES = 4'd5;

    logic [4:0] e_dst, e_rs, e_rt;
    logic [3:0] e_tnew;
    logic [4:0] m_dst;
    logic [3:0] m_tnew;
    // W tnew is always zero, so only its destination is kept.
    logic [4:0] w_dst;
    logic [3:0] md_cnt;

    logic stall_rs, stall_rt, stall_md, stall;

    function automatic logic reg_match(input logic [4:0] a, input logic [4:0] b);
        return (a != 5'd0) && (a == b);
    endfunction

    function automatic logic operand_stall(input logic [4:0] addr, input logic [3:0] tuse,
                                           input logic [4:0] ed, input logic [3:0] et,
                                           input logic [4:0] md, input logic [3:0] mt);
        return (tuse != USE_NONE) &&
               ((reg_match(addr, ed) && (et > tuse)) || (reg_match(addr, md) && (mt > tuse)));
    endfunction

    function automatic logic [1:0] fwd_d_sel(input logic [4:0] addr,
                                             input logic [4:0] ed, input logic [3:0] et,
                                             input logic [4:0] md, input logic [3:0] mt);
        if (reg_match(addr, ed) && (et == 4'd0))
            return 2'b01;
        else if (reg_match(addr, md) && (mt == 4'd0))
            return 2'b10;
        return 2'b00;
    endfunction

    function automatic logic [1:0] fwd_e_sel(input logic [4:0] addr,
                                             input logic [4:0] md, input logic [3:0] mt,
                                             input logic [4:0] wd);
        if (reg_match(addr, md) && (mt == 4'd0))
            return 2'b01;
        else if (reg_match(addr, wd))
            return 2'b10;
        return 2'b00;
    endfunction

    always_comb begin
        stall_rs = operand_stall(hz.d_rs_addr, hz.d_rs_use, e_dst, e_tnew, m_dst, m_tnew);
        stall_rt = operand_stall(hz.d_rt_addr, hz.d_rt_use, e_dst, e_tnew, m_dst, m_tnew);
        stall_md = hz.d_md_op && (md_cnt != 4'd0);
        stall    = stall_rs || stall_rt || stall_md;
    end

    assign hz.stall    = stall;
    assign hz.md_busy  = (md_cnt != 4'd0);
    assign hz.fwd_rs_d = fwd_d_sel(hz.d_rs_addr, e_dst, e_tnew, m_dst, m_tnew);
    assign hz.fwd_rt_d = fwd_d_sel(hz.d_rt_addr, e_dst, e_tnew, m_dst, m_tnew);
    assign hz.fwd_rs_e = fwd_e_sel(e_rs, m_dst, m_tnew, w_dst);
    assign hz.fwd_rt_e = fwd_e_sel(e_rt, m_dst, m_tnew, w_dst);

    always_ff @(posedge clk) begin
        if (reset) begin
            e_dst  <= 5'd0;
            e_rs   <= 5'd0;
            e_rt   <= 5'd0;
            e_tnew <= 4'd0;
            m_dst  <= 5'd0;
            m_tnew <= 4'd0;
            w_dst  <= 5'd0;
            md_cnt <= 4'd0;
        end else begin
            if (stall) begin
                e_dst  <= 5'd0;
                e_rs   <= 5'd0;
                e_rt   <= 5'd0;
                e_tnew <= 4'd0;
            end else begin
                e_dst  <= hz.d_dst_addr;
                e_rs   <= hz.d_rs_addr;
                e_rt   <= hz.d_rt_addr;
                e_tnew <= hz.d_dst_save;
            end
            m_dst  <= e_dst;
            m_tnew <= (e_tnew == 4'd0) ? 4'd0 : e_tnew - 4'd1;
            w_dst  <= m_dst;
            // A stalled start never loads; it waits in D for the busy window to end.
            if (!stall && hz.d_md_start)
                md_cnt <= hz.d_md_div ? MD_DIV_CYCLES : MD_MUL_CYCLES;
            else if (md_cnt != 4'd0)
                md_cnt <= md_cnt - 4'd1;
        end
    end
endmodule
